// File: rtl/systolic_feed_ctrl.sv
// Feed sequencer for a DIM x DIM output-stationary systolic array: latches A/B,
// clears the array, streams skewed rows/columns, waits out the array latency, captures results.
module systolic_feed_ctrl #(
    parameter  int BUS_WIDTH  = 32,
    parameter  int DATA_WIDTH = 8,
    parameter  int ARR_LAT    = 1,
    localparam int DIM        = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic [DIM*DIM*DATA_WIDTH-1:0]     a_mat_i,
    input  logic [DIM*DIM*DATA_WIDTH-1:0]     b_mat_i,
    output logic [DIM*DATA_WIDTH-1:0]         west_o,
    output logic [DIM*DATA_WIDTH-1:0]         north_o,
    output logic                              arr_clr_o,
    input  logic [DIM*BUS_WIDTH*DIM-1:0]      fin_r_i,
    input  logic [DIM*DIM-1:0]                ouflow_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [DIM*BUS_WIDTH*DIM-1:0]      result_o,
    output logic [DIM*DIM-1:0]                ovf_o
);

    localparam int KW     = $clog2(3 * DIM);
    localparam int K_LAST = 3 * DIM - 3;
    localparam int WW     = (ARR_LAT > 1) ? $clog2(ARR_LAT) : 1;
    localparam logic [WW-1:0] W_INIT = (ARR_LAT > 0) ? WW'(ARR_LAT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e                              state_q;
    logic [KW-1:0]                       k_q;
    logic [WW-1:0]                       wcnt_q;
    logic [DIM*DIM*DATA_WIDTH-1:0]       a_q, b_q;
    logic [DIM*DATA_WIDTH-1:0]           west_q, north_q;
    logic                                arr_clr_q, busy_q, done_q;
    logic [DIM*BUS_WIDTH*DIM-1:0]        result_q;
    logic [DIM*DIM-1:0]                  ovf_q;

    logic [KW-1:0]                       k_d;
    logic [DIM*DATA_WIDTH-1:0]           west_d, north_d;

    // Operand pattern for the feed step that the next edge will present.
    always_comb begin
        k_d     = (state_q == S_CLEAR) ? '0 : k_q + KW'(1);
        west_d  = '0;
        north_d = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                if (k_d == KW'(r + c)) begin
                    west_d[r*DATA_WIDTH +: DATA_WIDTH]  = a_q[(r*DIM + c)*DATA_WIDTH +: DATA_WIDTH];
                    north_d[c*DATA_WIDTH +: DATA_WIDTH] = b_q[(r*DIM + c)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            wcnt_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            west_q    <= '0;
            north_q   <= '0;
            arr_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            ovf_q     <= '0;
        end else begin
            west_q    <= '0;
            north_q   <= '0;
            arr_clr_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q       <= a_mat_i;
                        b_q       <= b_mat_i;
                        arr_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    k_q     <= k_d;
                    west_q  <= west_d;
                    north_q <= north_d;
                    state_q <= S_FEED;
                end
                S_FEED: begin
                    if (k_q == KW'(K_LAST)) begin
                        k_q <= '0;
                        if (ARR_LAT == 0) begin
                            result_q <= fin_r_i;
                            ovf_q    <= ouflow_i;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            wcnt_q  <= W_INIT;
                            state_q <= S_WAIT;
                        end
                    end else begin
                        k_q     <= k_d;
                        west_q  <= west_d;
                        north_q <= north_d;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == '0) begin
                        result_q <= fin_r_i;
                        ovf_q    <= ouflow_i;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        wcnt_q <= wcnt_q - WW'(1);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign west_o    = west_q;
    assign north_o   = north_q;
    assign arr_clr_o = arr_clr_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign result_o  = result_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: behavioural array model on the feed outputs, expected
// feed patterns and products computed directly from the matrices.
module tb_systolic_feed_ctrl;

    localparam int DW  = 8;
    localparam int BW  = 32;
    localparam int DIM = 4;
    localparam int MW  = DIM*DIM*DW;
    localparam int RW  = DIM*BW*DIM;

    typedef logic [DW-1:0] mat_t [DIM][DIM];

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            start_i;
    logic [MW-1:0]   a_mat_i, b_mat_i;
    logic [DIM*DW-1:0] west_o, north_o;
    logic            arr_clr_o;
    logic [RW-1:0]   fin_r_i;
    logic [DIM*DIM-1:0] ouflow_i;
    logic            busy_o, done_o;
    logic [RW-1:0]   result_o;
    logic [DIM*DIM-1:0] ovf_o;

    int n_chk  = 0;
    int n_pass = 0;
    bit force_ovf = 1'b0;
    logic [RW-1:0]      last_res = '0;
    logic [DIM*DIM-1:0] last_ovf = '0;

    systolic_feed_ctrl #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .ARR_LAT(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .a_mat_i(a_mat_i), .b_mat_i(b_mat_i),
        .west_o(west_o), .north_o(north_o), .arr_clr_o(arr_clr_o),
        .fin_r_i(fin_r_i), .ouflow_i(ouflow_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Array model: operands hop one PE east/south per cycle, each PE accumulates a*b.
    logic [DW-1:0] pa [DIM][DIM];
    logic [DW-1:0] pb [DIM][DIM];
    logic [DW-1:0] ain [DIM][DIM];
    logic [DW-1:0] bin [DIM][DIM];
    logic [BW-1:0] acc [DIM][DIM];

    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            ain[i][0] = west_o[i*DW +: DW];
            bin[0][i] = north_o[i*DW +: DW];
            for (int j = 1; j < DIM; j++) begin
                ain[i][j] = pa[i][j-1];
                bin[j][i] = pb[j-1][i];
            end
        end
    end

    always @(posedge clk_i or negedge rst_ni) begin
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                if (!rst_ni || arr_clr_o) begin
                    acc[i][j] <= '0;
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                end else begin
                    acc[i][j] <= acc[i][j] + BW'(ain[i][j]) * BW'(bin[i][j]);
                    pa[i][j]  <= ain[i][j];
                    pb[i][j]  <= bin[i][j];
                end
            end
        end
    end

    always_comb begin
        fin_r_i = '0;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                fin_r_i[(i*DIM+j)*BW +: BW] = acc[i][j];
        ouflow_i = force_ovf ? 16'h0020 : 16'h0000;
    end

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [MW-1:0] pack(input mat_t m);
        logic [MW-1:0] p;
        p = '0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                p[(r*DIM+c)*DW +: DW] = m[r][c];
        return p;
    endfunction

    function automatic logic [DIM*DW-1:0] exp_west(input mat_t a, input int k);
        logic [DIM*DW-1:0] v;
        v = '0;
        for (int i = 0; i < DIM; i++)
            if (k - i >= 0 && k - i < DIM) v[i*DW +: DW] = a[i][k-i];
        return v;
    endfunction

    function automatic logic [DIM*DW-1:0] exp_north(input mat_t b, input int k);
        logic [DIM*DW-1:0] v;
        v = '0;
        for (int j = 0; j < DIM; j++)
            if (k - j >= 0 && k - j < DIM) v[j*DW +: DW] = b[k-j][j];
        return v;
    endfunction

    function automatic logic [RW-1:0] exp_res(input mat_t a, input mat_t b);
        logic [RW-1:0] v;
        int unsigned s;
        v = '0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                s = 0;
                for (int m = 0; m < DIM; m++) s += int'(a[r][m]) * int'(b[m][c]);
                v[(r*DIM+c)*BW +: BW] = s;
            end
        return v;
    endfunction

    task automatic rand_mat(output mat_t m);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) m[r][c] = DW'($urandom);
    endtask

    task automatic fill_mat(output mat_t m, input int kind);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                case (kind)
                    0: m[r][c] = '0;
                    1: m[r][c] = (r == c) ? 8'd1 : 8'd0;
                    2: m[r][c] = DW'(r*DIM + c);
                    default: m[r][c] = 8'd255;
                endcase
    endtask

    // One run from a start at the next negedge; rst_k >= 0 aborts with reset in FEED k=rst_k.
    task automatic do_run(input mat_t a, input mat_t b, input bit scramble, input bit poke, input int rst_k);
        @(negedge clk_i);
        a_mat_i = pack(a);
        b_mat_i = pack(b);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        if (scramble) begin
            a_mat_i = {4{$urandom}};
            b_mat_i = {4{$urandom}};
        end
        check("clear_arr_clr", RW'(arr_clr_o), RW'(1));
        check("clear_busy", RW'(busy_o), RW'(1));
        check("clear_feed_zero", RW'({west_o, north_o}), '0);
        for (int k = 0; k <= 3*DIM-3; k++) begin
            @(negedge clk_i);
            if (k == rst_k) begin
                rst_ni = 1'b0;
                #1;
                check("rst_feed", RW'({west_o, north_o}), '0);
                check("rst_ctrl", RW'({arr_clr_o, busy_o, done_o}), '0);
                check("rst_result", result_o, '0);
                check("rst_ovf", RW'(ovf_o), '0);
                last_res = '0;
                last_ovf = '0;
                @(negedge clk_i);
                rst_ni = 1'b1;
                for (int n = 0; n < 14; n++) begin
                    @(negedge clk_i);
                    check("rst_no_done", RW'({done_o, busy_o}), '0);
                end
                return;
            end
            check($sformatf("west_k%0d", k), RW'(west_o), RW'(exp_west(a, k)));
            check($sformatf("north_k%0d", k), RW'(north_o), RW'(exp_north(b, k)));
            if (k == 5) check("result_hold", result_o, last_res);
            if (poke && k == 3) begin
                start_i = 1'b1;
                a_mat_i = {4{$urandom}};
            end
            if (poke && k == 4) start_i = 1'b0;
        end
        @(negedge clk_i);
        check("wait_state", RW'({west_o, north_o, arr_clr_o, done_o, busy_o}), RW'(1));
        @(negedge clk_i);
        last_res = exp_res(a, b);
        last_ovf = force_ovf ? 16'h0020 : 16'h0000;
        check("done_pulse", RW'({done_o, busy_o}), RW'(3));
        check("result", result_o, last_res);
        check("ovf", RW'(ovf_o), RW'(last_ovf));
        @(negedge clk_i);
        check("idle_after", RW'({done_o, busy_o}), '0);
    endtask

    mat_t ma, mb;

    initial begin
        rst_ni   = 1'b0;
        start_i  = 1'b0;
        a_mat_i  = '0;
        b_mat_i  = '0;
        #12;
        check("reset_feed", RW'({west_o, north_o, arr_clr_o}), '0);
        check("reset_busy_done", RW'({busy_o, done_o}), '0);
        check("reset_result", result_o, '0);
        check("reset_ovf", RW'(ovf_o), '0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        fill_mat(ma, 0);
        fill_mat(mb, 0);
        ma[0][0] = 8'd4; ma[1][0] = 8'd2; ma[2][0] = 8'd7;
        mb[0][0] = 8'd3; mb[0][1] = 8'd3; mb[0][2] = 8'd1;
        do_run(ma, mb, 1'b0, 1'b0, -1);

        fill_mat(ma, 1);
        fill_mat(mb, 2);
        do_run(ma, mb, 1'b1, 1'b0, -1);

        fill_mat(ma, 3);
        fill_mat(mb, 3);
        do_run(ma, mb, 1'b0, 1'b0, -1);
        force_ovf = 1'b1;
        do_run(ma, mb, 1'b0, 1'b0, -1);
        force_ovf = 1'b0;

        for (int t = 0; t < 6; t++) begin
            rand_mat(ma);
            rand_mat(mb);
            do_run(ma, mb, 1'($urandom), 1'($urandom), -1);
        end

        // start held high: accepted every 14 cycles, busy low for one cycle between runs
        rand_mat(ma);
        rand_mat(mb);
        @(negedge clk_i);
        a_mat_i = pack(ma);
        b_mat_i = pack(mb);
        start_i = 1'b1;
        for (int n = 1; n <= 42; n++) begin
            @(negedge clk_i);
            check($sformatf("cont_busy_n%0d", n), RW'(busy_o), RW'((n % 14) != 0));
            check($sformatf("cont_done_n%0d", n), RW'(done_o), RW'((n % 14) == 13));
            if (n % 14 == 13) check("cont_result", result_o, exp_res(ma, mb));
        end
        start_i = 1'b0;
        last_res = exp_res(ma, mb);
        @(negedge clk_i);
        check("cont_stop", RW'(busy_o), '0);

        rand_mat(ma);
        rand_mat(mb);
        do_run(ma, mb, 1'b0, 1'b0, 5);
        rand_mat(ma);
        rand_mat(mb);
        do_run(ma, mb, 1'b1, 1'b1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Sequencer that drives one DIM x DIM systolic multiply array. It latches two packed DIM x DIM operand matrices on a start request, clears the array, and feeds rows of A on the west edge and columns of B on the north edge with the diagonal skew the array requires, inserting zeros where no operand applies. It then waits for the array to drain, captures the array's result and overflow vectors, and pulses completion. It replaces hand-built skewed stimulus and is the block through which the multiplier top talks to the array.

## Interface
- BUS_WIDTH, 32, accumulator width per PE (array result element width)
- DATA_WIDTH, 8, operand element width
- DIM, BUS_WIDTH/DATA_WIDTH (localparam, 4), array dimension
- ARR_LAT, 1, cycles between the last feed cycle and the array result being valid
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  request; sampled only in IDLE
- a_mat_i  in  DIM*DIM*DATA_WIDTH  matrix A; element [r][c] at bits [(r*DIM+c)*DATA_WIDTH +: DATA_WIDTH]
- b_mat_i  in  DIM*DIM*DATA_WIDTH  matrix B, same packing
- west_o  out  DIM*DATA_WIDTH  to array west_i; lane i at [i*DATA_WIDTH +: DATA_WIDTH], lane 0 = LSB
- north_o  out  DIM*DATA_WIDTH  to array north_i, same lane packing
- arr_clr_o  out  1  accumulator clear to array (drives array start_bit)
- fin_r_i  in  DIM*BUS_WIDTH*DIM  array result vector
- ouflow_i  in  DIM*DIM  array per-PE overflow flags
- busy_o  out  1  high from the accepting edge until return to IDLE
- done_o  out  1  one-cycle completion pulse
- result_o  out  DIM*BUS_WIDTH*DIM  captured fin_r_i
- ovf_o  out  DIM*DIM  captured ouflow_i

## Operation
- FSM states: IDLE, CLEAR, FEED, WAIT, DONE.
- IDLE: when start_i=1, latch a_mat_i/b_mat_i into internal registers and go to CLEAR. Inputs may change after the accepting edge.
- CLEAR: one cycle with arr_clr_o=1 and west_o/north_o=0. Then go to FEED with k=0.
- FEED: counter k runs 0..3*DIM-3.
  - west lane i = A[i][k-i] when 0 <= k-i < DIM, else 0.
  - north lane j = B[k-j][j] when 0 <= k-j < DIM, else 0.
  - Nonzero data occupies k=0..2*DIM-2. The remaining cycles drive zeros so the last operands reach PE(DIM-1,DIM-1).
  - At k=3*DIM-3, go to WAIT. If ARR_LAT=0, go directly to DONE.
- WAIT: count ARR_LAT cycles with zero outputs, then go to DONE.
- DONE: on the entering edge, capture result_o<=fin_r_i and ovf_o<=ouflow_i. done_o=1 for this single cycle. Next edge returns to IDLE.
- start_i outside IDLE is ignored, including in DONE. There is no queueing.
- result_o/ovf_o hold until the next DONE entry.
- Reset, asynchronous, any state:
  - state=IDLE, k=0.
  - west_o, north_o, arr_clr_o, busy_o, done_o, result_o, ovf_o and the latched matrices all 0.
  - A run interrupted by reset is abandoned. No done_o is produced.
- west_o, north_o and arr_clr_o are registered outputs, and therefore glitch-free to the array.

## Timing
- Let E0 be the edge that samples start_i=1 in IDLE.
- CLEAR occupies the cycle after E0. FEED k occupies the cycle after edge E(1+k).
- DONE is entered at edge E(3*DIM-1+ARR_LAT). With defaults this is E12, and done_o is high during the cycle after E12.
- busy_o rises at E0 and falls at the edge leaving DONE.
- Back-to-back runs: the earliest next accepting edge is the edge leaving DONE plus one, because IDLE must be seen for one edge.
- Total cycles from start to done_o with defaults: 13 (CLEAR 1, FEED 10, WAIT 1, DONE 1).

## Test plan
- Skew check, DIM=4: A[0][0]=4, A[1][0]=2, A[2][0]=7, B[0][0]=3, B[0][1]=3, B[0][2]=1, all other elements 0. Required west_o: k=0 lane0=4; k=1 lane1=2; k=2 lane2=7. Required north_o: k=0 lane0=3; k=1 lane1=3; k=2 lane2=1. All other lanes and cycles 0.
- Full multiply against a behavioural array model: A=identity, B[r][c]=r*4+c → result_o element [r][c] = r*4+c, ovf_o=0, done_o exactly 13 cycles after start.
- All elements 255 in A and B → every result element is 260100 (4*65025) and ovf_o=0. If the model forces ouflow_i[5]=1 at capture, ovf_o=16'h0020.
- start_i held high continuously → runs accepted every 14 cycles. busy_o shows a one-cycle low between runs. Pulses of start_i during FEED are ignored, and result_o is unchanged mid-run.
- Assert rst_ni low during FEED k=5 → all outputs 0 immediately (asynchronous), no done_o. A fresh start after release completes normally.
- Change a_mat_i/b_mat_i on the cycle after E0 → the fed data equals the values latched at E0.
